// File: rtl/arashi_pkg.sv
// Shared types and sizing constants for the arashi read sequencer.
package arashi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READY    = 2'd1,
        INFLIGHT = 2'd2,
        DRAIN    = 2'd3
    } thread_state_t;

    localparam int READER_FIFO_DEPTH = 4;
    // Grants stop at this occupancy so the grant already registered in the
    // arbiter always finds room.
    localparam int READER_THROTTLE   = 2;

endpackage

// File: rtl/arashi_req_fifo.sv
// Small synchronous FIFO for tagged read requests. Push and pop may happen in
// the same cycle at any occupancy, including full. DEPTH must be a power of 2.
module arashi_req_fifo #(
    parameter  int WIDTH = 18,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pop only when data exists; a push into a full FIFO is only taken if a
    // pop frees the slot in the same cycle.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && (!full || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/arashi_reader.sv
// Per-thread memory read sequencer behind the round-robin thread arbiter.
// Optional feature macro: ARASHI_READER_PERF_EN adds perf_grants/perf_drops
// saturating counters and their output ports.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | thread not loaded; start moves it to READY
// READY    | eligible for a grant; accepted grant -> INFLIGHT
// INFLIGHT | one read outstanding; response -> READY, stop -> DRAIN
// DRAIN    | retired with a read outstanding; response -> IDLE
module arashi_reader
    import arashi_pkg::*;
#(
    parameter  int DATA_WIDTH       = 32,
    parameter  int MEM_WIDTH        = 16,
    parameter  int THREAD_NUM_WIDTH = 2,
    localparam int THREAD_NUM       = 1 << THREAD_NUM_WIDTH
) (
    input  logic                        clk,
    input  logic                        rstn,
    output logic [THREAD_NUM-1:0]       avail,
    input  logic [THREAD_NUM_WIDTH-1:0] toread,
    input  logic                        rcache,
    input  logic                        start_valid,
    input  logic [THREAD_NUM_WIDTH-1:0] start_tid,
    input  logic [MEM_WIDTH-1:0]        start_addr,
    input  logic                        stop_valid,
    input  logic [THREAD_NUM_WIDTH-1:0] stop_tid,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic [MEM_WIDTH-1:0]        mem_req_addr,
    output logic [THREAD_NUM_WIDTH-1:0] mem_req_tid,
    input  logic                        mem_rsp_valid,
    input  logic [THREAD_NUM_WIDTH-1:0] mem_rsp_tid,
    input  logic [DATA_WIDTH-1:0]       mem_rsp_data,
    output logic                        out_valid,
    output logic [THREAD_NUM_WIDTH-1:0] out_tid,
    output logic [DATA_WIDTH-1:0]       out_data
`ifdef ARASHI_READER_PERF_EN
    ,
    output logic [31:0]                 perf_grants,
    output logic [31:0]                 perf_drops
`endif
);

    localparam int REQ_W = THREAD_NUM_WIDTH + MEM_WIDTH;
    localparam int CNT_W = $clog2(READER_FIFO_DEPTH + 1);

    thread_state_t               state_q [THREAD_NUM];
    thread_state_t               state_d [THREAD_NUM];
    logic [MEM_WIDTH-1:0]        addr_q  [THREAD_NUM];
    logic [MEM_WIDTH-1:0]        addr_d  [THREAD_NUM];

    logic [THREAD_NUM-1:0]       eligible;
    logic [THREAD_NUM-1:0]       start_hit;
    logic [THREAD_NUM-1:0]       stop_hit;
    logic [THREAD_NUM-1:0]       rsp_hit;
    logic [THREAD_NUM-1:0]       grant_hit;
    logic                        throttle;
    logic                        grant_ok;
    logic                        rsp_ok;
    thread_state_t               rsp_state;

    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_empty;
    logic [REQ_W-1:0]            fifo_head;

    logic                        out_valid_q;
    logic [THREAD_NUM_WIDTH-1:0] out_tid_q;
    logic [DATA_WIDTH-1:0]       out_data_q;

    // Grant acceptance, response legality and per-thread event decode.
    // A stop to the granted thread in the same cycle cancels the grant.
    always_comb begin
        throttle  = (fifo_count >= CNT_W'(READER_THROTTLE));
        grant_ok  = rcache && (state_q[toread] == READY) && !throttle
                    && !(stop_valid && (stop_tid == toread));
        rsp_state = state_q[mem_rsp_tid];
        rsp_ok    = mem_rsp_valid && ((rsp_state == INFLIGHT) || (rsp_state == DRAIN));
        eligible  = '0;
        avail     = '0;
        start_hit = '0;
        stop_hit  = '0;
        rsp_hit   = '0;
        grant_hit = '0;
        for (int t = 0; t < THREAD_NUM; t++) begin
            eligible[t]  = (state_q[t] == READY);
            avail[t]     = eligible[t] && !throttle
                           && !(rcache && (toread == THREAD_NUM_WIDTH'(t)));
            start_hit[t] = start_valid && (start_tid == THREAD_NUM_WIDTH'(t));
            stop_hit[t]  = stop_valid && (stop_tid == THREAD_NUM_WIDTH'(t));
            rsp_hit[t]   = mem_rsp_valid && (mem_rsp_tid == THREAD_NUM_WIDTH'(t));
            grant_hit[t] = grant_ok && (toread == THREAD_NUM_WIDTH'(t));
        end
    end

    // Per-thread next state and address. A response is applied before a
    // stop in the same cycle, so INFLIGHT + response + stop lands in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        for (int t = 0; t < THREAD_NUM; t++) begin
            unique case (state_q[t])
                IDLE: begin
                    if (start_hit[t]) begin
                        state_d[t] = READY;
                        addr_d[t]  = start_addr;
                    end
                end
                READY: begin
                    if (stop_hit[t]) begin
                        state_d[t] = IDLE;
                    end else if (grant_hit[t]) begin
                        state_d[t] = INFLIGHT;
                    end
                end
                INFLIGHT: begin
                    if (rsp_hit[t]) begin
                        state_d[t] = stop_hit[t] ? IDLE : READY;
                    end else if (stop_hit[t]) begin
                        state_d[t] = DRAIN;
                    end
                end
                DRAIN: begin
                    if (rsp_hit[t]) begin
                        state_d[t] = IDLE;
                    end
                end
                default: state_d[t] = IDLE;
            endcase
            if (grant_hit[t]) begin
                addr_d[t] = addr_q[t] + MEM_WIDTH'(1);
            end
        end
    end

    // Thread state and address registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int t = 0; t < THREAD_NUM; t++) begin
                state_q[t] <= IDLE;
                addr_q[t]  <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    arashi_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (READER_FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (grant_ok),
        .push_data_i ({toread, addr_q[toread]}),
        .pop_i       (mem_req_ready),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    // Request bus is held at zero whenever nothing is queued.
    assign mem_req_valid = !fifo_empty;
    assign {mem_req_tid, mem_req_addr} = fifo_empty ? '0 : fifo_head;

    // Registered return path; illegal responses never reach the pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_tid_q   <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rsp_ok;
            if (rsp_ok) begin
                out_tid_q  <= mem_rsp_tid;
                out_data_q <= mem_rsp_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_tid   = out_tid_q;
    assign out_data  = out_data_q;

`ifndef SYNTHESIS
    // Flag responses for threads that have no read outstanding.
    always @(posedge clk) begin
        if (rstn && mem_rsp_valid && !rsp_ok) begin
            $error("arashi_reader: response for thread %0d with no read outstanding", mem_rsp_tid);
        end
    end
`endif

`ifdef ARASHI_READER_PERF_EN
    logic [31:0] perf_grants_q;
    logic [31:0] perf_drops_q;

    // Saturating counts of accepted and refused grant strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_grants_q <= '0;
            perf_drops_q  <= '0;
        end else begin
            if (grant_ok && (perf_grants_q != '1)) begin
                perf_grants_q <= perf_grants_q + 32'd1;
            end
            if (rcache && !grant_ok && (perf_drops_q != '1)) begin
                perf_drops_q <= perf_drops_q + 32'd1;
            end
        end
    end

    assign perf_grants = perf_grants_q;
    assign perf_drops  = perf_drops_q;
`endif

endmodule

// File: tb/tb_arashi_reader.sv
// Bench for arashi_reader: round-robin arbiter model, one-cycle memory
// responder, scoreboard on the return path, and a per-cycle vector table.
module tb_arashi_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  avail;
    logic [1:0]  toread;
    logic        rcache;
    logic        start_valid;
    logic [1:0]  start_tid;
    logic [15:0] start_addr;
    logic        stop_valid;
    logic [1:0]  stop_tid;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic [1:0]  mem_req_tid;
    logic        mem_rsp_valid;
    logic [1:0]  mem_rsp_tid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic [1:0]  out_tid;
    logic [31:0] out_data;
`ifdef ARASHI_READER_PERF_EN
    logic [31:0] perf_grants;
    logic [31:0] perf_drops;
`endif

    always #5 clk = ~clk;

    arashi_reader #(.DATA_WIDTH(32), .MEM_WIDTH(16), .THREAD_NUM_WIDTH(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .avail         (avail),
        .toread        (toread),
        .rcache        (rcache),
        .start_valid   (start_valid),
        .start_tid     (start_tid),
        .start_addr    (start_addr),
        .stop_valid    (stop_valid),
        .stop_tid      (stop_tid),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_tid   (mem_req_tid),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_tid   (mem_rsp_tid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_tid       (out_tid),
        .out_data      (out_data)
`ifdef ARASHI_READER_PERF_EN
        ,
        .perf_grants   (perf_grants),
        .perf_drops    (perf_drops)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dfn(input logic [1:0] t, input logic [15:0] a);
        return {8'hA5, 6'h00, t, a};
    endfunction

    // Arbiter model: registered round-robin pick among avail bits.
    logic       arb_en;
    logic       arb_rcache;
    logic [1:0] arb_toread;
    logic [1:0] arb_last;
    logic       arb_found;
    logic [1:0] arb_pick;
    logic [1:0] arb_cand;
    logic       man_rcache;
    logic [1:0] man_toread;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arb_rcache <= 1'b0;
            arb_toread <= 2'd0;
            arb_last   <= 2'd3;
        end else if (!arb_en) begin
            arb_rcache <= 1'b0;
        end else begin
            arb_found = 1'b0;
            arb_pick  = 2'd0;
            for (int i = 1; i <= 4; i++) begin
                arb_cand = arb_last + 2'(i);
                if (!arb_found && avail[arb_cand]) begin
                    arb_found = 1'b1;
                    arb_pick  = arb_cand;
                end
            end
            arb_rcache <= arb_found;
            if (arb_found) begin
                arb_toread <= arb_pick;
                arb_last   <= arb_pick;
            end
        end
    end

    assign rcache = arb_en ? arb_rcache : man_rcache;
    assign toread = arb_en ? arb_toread : man_toread;

    // Memory model: answers each accepted request one cycle later.
    logic        auto_rsp;
    logic        auto_v;
    logic [1:0]  auto_tid;
    logic [31:0] auto_data;
    logic        man_v;
    logic [1:0]  man_tid;
    logic [31:0] man_data;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            auto_v    <= 1'b0;
            auto_tid  <= 2'd0;
            auto_data <= 32'd0;
        end else begin
            auto_v    <= auto_rsp && mem_req_valid && mem_req_ready;
            auto_tid  <= mem_req_tid;
            auto_data <= dfn(mem_req_tid, mem_req_addr);
        end
    end

    assign mem_rsp_valid = auto_v | man_v;
    assign mem_rsp_tid   = man_v ? man_tid : auto_tid;
    assign mem_rsp_data  = man_v ? man_data : auto_data;

    // Scoreboard and request monitor, sampled on the falling edge.
    typedef struct {
        logic [1:0]  tid;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [1:0]  req_log[$];
    logic [15:0] exp_addr[4];
    int          outstanding[4];
    logic        mon_req_en;

    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL out_unexpected: out_valid=1 tid %0d, expected no output", out_tid);
                end else begin
                    e = exp_q.pop_front();
                    check("out_tid", 32'(out_tid), 32'(e.tid));
                    check("out_data", out_data, e.data);
                    if (outstanding[out_tid] > 0) outstanding[out_tid]--;
                end
            end
            if (mon_req_en && mem_req_valid && mem_req_ready) begin
                check("one_outstanding", 32'(outstanding[mem_req_tid]), 32'd0);
                check("req_addr", 32'(mem_req_addr), 32'(exp_addr[mem_req_tid]));
                if (auto_rsp) exp_q.push_back('{tid: mem_req_tid, data: dfn(mem_req_tid, exp_addr[mem_req_tid])});
                exp_addr[mem_req_tid] = exp_addr[mem_req_tid] + 16'd1;
                outstanding[mem_req_tid]++;
                req_log.push_back(mem_req_tid);
            end
            if (mon_req_en && start_valid) exp_addr[start_tid] = start_addr;
        end
    end

    task automatic clear_drives();
        start_valid = 1'b0; start_tid = 2'd0; start_addr = 16'd0;
        stop_valid  = 1'b0; stop_tid  = 2'd0;
        man_rcache  = 1'b0; man_toread = 2'd0;
        man_v = 1'b0; man_tid = 2'd0; man_data = 32'd0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rstn = 1'b0;
        arb_en = 1'b0; auto_rsp = 1'b0; mon_req_en = 1'b0; mem_req_ready = 1'b0;
        clear_drives();
        exp_q.delete();
        req_log.delete();
        for (int i = 0; i < 4; i++) begin
            outstanding[i] = 0;
            exp_addr[i] = 16'd0;
        end
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    task automatic start_thread(input logic [1:0] t, input logic [15:0] a);
        @(posedge clk); #2;
        start_valid = 1'b1; start_tid = t; start_addr = a;
        @(posedge clk); #2;
        start_valid = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int budget, input string name);
        int c = 0;
        while (req_log.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        check(name, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic drain_check(input string name);
        arb_en = 1'b0;
        repeat (12) @(posedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic        sv; logic [1:0] st; logic [15:0] sa;
        logic        pv; logic [1:0] pt;
        logic        rc; logic [1:0] tr;
        logic        rv; logic [1:0] rt; logic [31:0] rd;
        logic [3:0]  ea;
        logic        ev; logic [1:0] et; logic [15:0] eaddr;
    } vec_t;

    localparam int NV = 18;
    vec_t vt[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        arb_en = 1'b0; auto_rsp = 1'b0; mon_req_en = 1'b0; mem_req_ready = 1'b0;
        clear_drives();

        // Reset state.
        #3;
        check("rst_avail", 32'(avail), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_req_addr", 32'(mem_req_addr), 32'd0);
        check("rst_req_tid", 32'(mem_req_tid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_tid", 32'(out_tid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        do_reset();

        // Per-cycle vectors, manual arbiter and responses, mem_req_ready=1.
        //          sv st sa        pv pt rc tr rv rt rd            ea       ev et eaddr
        vt[0]  = '{1, 1, 16'h0020, 0, 0, 0, 0, 0, 0, 32'h0,        4'b0000, 0, 0, 16'h0};
        vt[1]  = '{1, 0, 16'h0040, 0, 0, 0, 0, 0, 0, 32'h0,        4'b0010, 0, 0, 16'h0};
        vt[2]  = '{0, 0, 16'h0000, 0, 0, 1, 1, 0, 0, 32'h0,        4'b0001, 0, 0, 16'h0};
        vt[3]  = '{0, 0, 16'h0000, 0, 0, 1, 1, 0, 0, 32'h0,        4'b0001, 1, 1, 16'h0020};
        vt[4]  = '{0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 32'h0,        4'b0000, 0, 0, 16'h0};
        vt[5]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 32'h0,        4'b0000, 0, 0, 16'h0};
        vt[6]  = '{1, 2, 16'hFFFF, 1, 1, 0, 0, 0, 0, 32'h0,        4'b0000, 0, 0, 16'h0};
        vt[7]  = '{1, 1, 16'h0077, 0, 0, 0, 0, 0, 0, 32'h0,        4'b0100, 0, 0, 16'h0};
        vt[8]  = '{0, 0, 16'h0000, 0, 0, 1, 2, 0, 0, 32'h0,        4'b0000, 0, 0, 16'h0};
        vt[9]  = '{1, 3, 16'h0005, 0, 0, 0, 0, 0, 0, 32'h0,        4'b0000, 1, 2, 16'hFFFF};
        vt[10] = '{0, 0, 16'h0000, 0, 0, 0, 0, 1, 2, 32'hCAFE0010, 4'b1000, 0, 0, 16'h0};
        vt[11] = '{0, 0, 16'h0000, 0, 0, 1, 3, 0, 0, 32'h0,        4'b0100, 0, 0, 16'h0};
        vt[12] = '{0, 0, 16'h0000, 0, 0, 1, 2, 0, 0, 32'h0,        4'b0000, 1, 3, 16'h0005};
        vt[13] = '{0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 32'hCAFE0013, 4'b0000, 1, 2, 16'h0000};
        vt[14] = '{0, 0, 16'h0000, 1, 3, 0, 0, 1, 3, 32'hCAFE0014, 4'b0000, 0, 0, 16'h0};
        vt[15] = '{0, 0, 16'h0000, 0, 0, 0, 0, 1, 2, 32'hCAFE0015, 4'b0000, 0, 0, 16'h0};
        vt[16] = '{0, 0, 16'h0000, 1, 2, 0, 0, 0, 0, 32'h0,        4'b0100, 0, 0, 16'h0};
        vt[17] = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 32'h0,        4'b0000, 0, 0, 16'h0};

        mem_req_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #2;
            start_valid = vt[i].sv; start_tid = vt[i].st; start_addr = vt[i].sa;
            stop_valid  = vt[i].pv; stop_tid  = vt[i].pt;
            man_rcache  = vt[i].rc; man_toread = vt[i].tr;
            man_v = vt[i].rv; man_tid = vt[i].rt; man_data = vt[i].rd;
            #1;
            check($sformatf("vec%0d_avail", i), 32'(avail), 32'(vt[i].ea));
            check($sformatf("vec%0d_req_valid", i), 32'(mem_req_valid), 32'(vt[i].ev));
            if (vt[i].ev) begin
                check($sformatf("vec%0d_req_tid", i), 32'(mem_req_tid), 32'(vt[i].et));
                check($sformatf("vec%0d_req_addr", i), 32'(mem_req_addr), 32'(vt[i].eaddr));
            end
            if (vt[i].rv) exp_q.push_back('{tid: vt[i].rt, data: vt[i].rd});
        end
        @(posedge clk); #2;
        clear_drives();
        repeat (3) @(posedge clk);
        check("vec_sb_drained", 32'(exp_q.size()), 32'd0);

        // Single thread streaming from 0x10.
        do_reset();
        mem_req_ready = 1'b1; auto_rsp = 1'b1; mon_req_en = 1'b1;
        start_thread(2'd0, 16'h0010);
        arb_en = 1'b1;
        wait_reqs(6, 100, "t0_stream_reqs");
        if (req_log.size() >= 3) check("t0_third_tid", 32'(req_log[2]), 32'd0);
        check("t0_next_addr", 32'(exp_addr[0] >= 16'h0016), 32'd1);
        drain_check("t0_sb_drained");

        // Four threads, round-robin order.
        do_reset();
        mem_req_ready = 1'b1; auto_rsp = 1'b1; mon_req_en = 1'b1;
        for (int t = 0; t < 4; t++) start_thread(2'(t), 16'(16'h1000 * (t + 1)));
        arb_en = 1'b1;
        wait_reqs(5, 60, "rr_reqs");
        if (req_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) check($sformatf("rr_tid%0d", k), 32'(req_log[k]), 32'(k % 4));
        end
        drain_check("rr_sb_drained");

        // Memory stalled with four READY threads: throttle holds the FIFO at two.
        do_reset();
        mem_req_ready = 1'b0; auto_rsp = 1'b1; mon_req_en = 1'b1;
        for (int t = 0; t < 4; t++) start_thread(2'(t), 16'(16'h0100 * (t + 1)));
        arb_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #3;
            if (c >= 3) begin
                check($sformatf("stall_avail%0d", c), 32'(avail), 32'd0);
                check($sformatf("stall_req_valid%0d", c), 32'(mem_req_valid), 32'd1);
            end
        end
`ifdef ARASHI_READER_PERF_EN
        check("perf_grants", perf_grants, 32'd2);
        check("perf_drops_nonzero", 32'(perf_drops != 32'd0), 32'd1);
`endif
        mem_req_ready = 1'b1;
        wait_reqs(8, 80, "stall_release_reqs");
        if (req_log.size() >= 2) begin
            check("stall_first_tid", 32'(req_log[0]), 32'd0);
            check("stall_second_tid", 32'(req_log[1]), 32'd1);
        end
        drain_check("stall_sb_drained");

        // Reset with two queued requests; a response during reset is dropped.
        do_reset();
        mem_req_ready = 1'b0; auto_rsp = 1'b0; mon_req_en = 1'b0;
        for (int t = 0; t < 3; t++) start_thread(2'(t), 16'(16'h0300 + t));
        arb_en = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        check("pre_rst_req_valid", 32'(mem_req_valid), 32'd1);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("mid_rst_avail", 32'(avail), 32'd0);
        check("mid_rst_req_addr", 32'(mem_req_addr), 32'd0);
        arb_en = 1'b0;
        @(posedge clk); #2;
        man_v = 1'b1; man_tid = 2'd0; man_data = 32'hDEAD0001;
        @(posedge clk); #2;
        man_v = 1'b0;
        #1;
        check("late_rsp_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        rstn = 1'b1;
        @(posedge clk); #3;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_req_valid", 32'(mem_req_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arashi_reader.md
# arashi_reader

Per-thread memory read sequencer that sits directly downstream of the round-robin thread arbiter. It tracks a read address and state per thread and produces the arbiter's `avail` vector. It turns accepted arbiter grants (`toread`/`rcache`) into tagged memory read requests through a small request FIFO, and returns tagged read data to the thread pipeline.

## Interface
Parameters:
- DATA_WIDTH, 32, width of a memory read word
- MEM_WIDTH, 16, word-address width
- THREAD_NUM_WIDTH, 2, log2 of thread count; THREAD_NUM = 1 << THREAD_NUM_WIDTH

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low
- avail  out  THREAD_NUM  eligible threads, to arbiter
- toread  in  THREAD_NUM_WIDTH  arbiter-selected thread
- rcache  in  1  arbiter grant strobe
- start_valid  in  1  load a thread
- start_tid  in  THREAD_NUM_WIDTH  thread being loaded
- start_addr  in  MEM_WIDTH  first word address for the thread
- stop_valid  in  1  retire a thread
- stop_tid  in  THREAD_NUM_WIDTH  thread being retired
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  MEM_WIDTH  request address
- mem_req_tid  out  THREAD_NUM_WIDTH  request tag
- mem_rsp_valid  in  1  read data valid; no backpressure, any order
- mem_rsp_tid  in  THREAD_NUM_WIDTH  response tag
- mem_rsp_data  in  DATA_WIDTH  read data
- out_valid  out  1  data to thread pipeline
- out_tid  out  THREAD_NUM_WIDTH  owning thread
- out_data  out  DATA_WIDTH  read word

## Operation
Per-thread state:
- IDLE: start → READY.
- READY: accepted grant → INFLIGHT.
- INFLIGHT: response → READY; stop → DRAIN.
- DRAIN: response → IDLE.
- READY with stop → IDLE.

Eligibility and grants:
- eligible[t] = (state == READY).
- avail[t] = eligible[t] & ~(rcache & toread == t) & ~throttle. The masking is combinational, so the arbiter never re-grants the thread it just selected.
- A grant is accepted when rcache=1, eligible[toread]=1 and throttle=0.
- rcache=1 for an ineligible thread is ignored; the arbiter asserts rcache whenever any avail bit was set, and the selected thread may be stale.
- An accepted grant pushes {toread, addr[toread]} into a 4-entry request FIFO. addr[toread] then increments by 1, wrapping modulo 2^MEM_WIDTH.
- throttle = (fifo_count ≥ 2). This reserves slots for the grant already in flight in the arbiter's register.

Memory side:
- FIFO head drives mem_req_*; a pop occurs on mem_req_valid & mem_req_ready.
- On mem_rsp_valid: out_valid/out_tid/out_data are registered from mem_rsp_*, and the thread's state advances.
- A response for a thread in IDLE or READY is an error. It is dropped and out_valid stays 0. Under `ifndef SYNTHESIS` it raises `$error`.

Simultaneous events:
- Start on a non-IDLE thread: ignored.
- Stop on IDLE or DRAIN: ignored.
- Stop and accepted grant, same thread, same cycle: stop wins, grant is ignored, state → IDLE.
- Response and stop, same INFLIGHT thread, same cycle: response processed first → READY, then stop → IDLE.
- FIFO push and pop in the same cycle: legal at any count, including full.

## Timing
- Reset (async, rstn=0): all states IDLE, addr=0, FIFO empty.
- Outputs during reset: avail=0, mem_req_valid=0, mem_req_addr=0, mem_req_tid=0, out_valid=0, out_tid=0, out_data=0.
- Reset mid-operation discards FIFO contents and in-flight bookkeeping. Responses arriving after reset are dropped as errors.
- start at edge N → avail[t]=1 in cycle N+1.
- The arbiter registers a grant at edge N+2 → FIFO push at edge N+3 → mem_req_valid=1 in cycle N+3.
- mem_rsp_valid at edge M → out_valid=1 in cycle M+1 for exactly one cycle.
- Sustained throughput: one request per cycle while mem_req_ready=1 and eligible threads exist.

## Configuration
- ARASHI_READER_PERF_EN defined: adds output ports perf_grants[31:0] (accepted grants) and perf_drops[31:0] (rcache=1 grants not accepted). Both are saturating counters, reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- arashi_pkg holds:
  - enum `thread_state_t` {IDLE, READY, INFLIGHT, DRAIN}
  - localparam `READER_FIFO_DEPTH = 4`
  - localparam `READER_THROTTLE = 2`
- One sub-module: arashi_req_fifo, a parameterised-width synchronous FIFO with count output and simultaneous push/pop.

## Test plan
- Start t0 at addr 0x10, mem_req_ready=1, arbiter connected, one-cycle response loop → requests 0x10, 0x11, 0x12 … tagged 0; out_data follows.
- Start all 4 threads, ready=1 → mem_req_tid cycles 0,1,2,3,0; no thread has two requests outstanding.
- mem_req_ready=0 for 10 cycles with 4 READY threads → FIFO peaks at ≤4 with no overflow; avail=0 while count ≥2; perf_drops increments when enabled.
- Stop t1 while INFLIGHT, then respond → out_valid=1 with tid 1; t1 ends in IDLE; avail[1] stays 0.
- Start t2 at addr 0xFFFF with MEM_WIDTH=16 → requests 0xFFFF, then 0x0000.
- Assert rstn=0 with 2 FIFO entries queued → mem_req_valid=0 and avail=0 immediately; a late response produces no out_valid.
